// File: rtl/aes_mem_sequencer_if.sv
// Shared-memory port (s2) and AES core handshake seen by the sequencer.
// The master modport is the sequencer side; slave is memory plus AES core.
interface aes_mem_sequencer_if;
    logic [1:0]   mem_address;
    logic         mem_chipselect;
    logic         mem_write;
    logic [15:0]  mem_byteenable;
    logic [127:0] mem_writedata;
    logic [127:0] mem_readdata;
    logic         mem_clken;
    logic [127:0] aes_key;
    logic [127:0] aes_data;
    logic         aes_in_valid;
    logic         aes_in_ready;
    logic         aes_out_valid;
    logic [127:0] aes_out_data;

    modport master (
        output mem_address, mem_chipselect, mem_write, mem_byteenable,
               mem_writedata, mem_clken, aes_key, aes_data, aes_in_valid,
        input  mem_readdata, aes_in_ready, aes_out_valid, aes_out_data
    );

    modport slave (
        input  mem_address, mem_chipselect, mem_write, mem_byteenable,
               mem_writedata, mem_clken, aes_key, aes_data, aes_in_valid,
        output mem_readdata, aes_in_ready, aes_out_valid, aes_out_data
    );
endinterface

// File: rtl/aes_mem_sequencer.sv
// Polls a control word in a 4x128 shared memory, runs one AES job per START,
// writes the ciphertext back and posts DONE/ERR plus a running job count.
module aes_mem_sequencer #(
    parameter int unsigned POLL_INTERVAL  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                reset_n,
    aes_mem_sequencer_if.master bus,
    output logic                busy
);

    localparam int unsigned DATA_W = 128;
    localparam int unsigned BE_W   = 16;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned POLL_W = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam int unsigned TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [1:0] ADDR_CTRL = 2'd0;
    localparam logic [1:0] ADDR_KEY  = 2'd1;
    localparam logic [1:0] ADDR_DATA = 2'd2;
    localparam logic [1:0] ADDR_RES  = 2'd3;

    localparam logic [BE_W-1:0] BE_ALL  = 16'hFFFF;
    localparam logic [BE_W-1:0] BE_STAT = 16'h00FF;

    typedef enum logic [3:0] {
        IDLE, POLL_RD, POLL_CHK, KEY_RD, KEY_CAP, DATA_RD, DATA_CAP,
        AES_REQ, AES_WAIT, RES_WR, STAT_WR
    } state_t;

    state_t              state, state_nx;
    logic [POLL_W-1:0]   poll_cnt, poll_cnt_nx;
    logic [TMO_W-1:0]    tmo_cnt, tmo_cnt_nx;
    logic                err, err_nx;
    logic [CNT_W-1:0]    job_cnt, job_cnt_nx;
    logic [DATA_W-1:0]   key_q, key_nx;
    logic [DATA_W-1:0]   data_q, data_nx;
    logic [DATA_W-1:0]   result, result_nx;

    logic [1:0]          addr_q, addr_nx;
    logic                cs_q, cs_nx;
    logic                we_q, we_nx;
    logic [BE_W-1:0]     be_q, be_nx;
    logic [DATA_W-1:0]   wdata_q, wdata_nx;
    logic                in_valid_q, in_valid_nx;
    logic                busy_q, busy_nx;

    // Next state, datapath captures, then outputs decoded from the next state
    // so every bus output comes straight off a flop and lines up with state.
    always_comb begin
        state_nx    = state;
        poll_cnt_nx = '0;
        tmo_cnt_nx  = '0;
        err_nx      = err;
        job_cnt_nx  = job_cnt;
        key_nx      = key_q;
        data_nx     = data_q;
        result_nx   = result;

        case (state)
            IDLE: begin
                if (poll_cnt == POLL_W'(POLL_INTERVAL - 1)) begin
                    state_nx = POLL_RD;
                end else begin
                    poll_cnt_nx = poll_cnt + POLL_W'(1);
                end
            end
            POLL_RD:  state_nx = POLL_CHK;
            POLL_CHK: state_nx = bus.mem_readdata[0] ? KEY_RD : IDLE;
            KEY_RD:   state_nx = KEY_CAP;
            KEY_CAP: begin
                key_nx   = bus.mem_readdata;
                state_nx = DATA_RD;
            end
            DATA_RD:  state_nx = DATA_CAP;
            DATA_CAP: begin
                data_nx  = bus.mem_readdata;
                state_nx = AES_REQ;
            end
            AES_REQ: begin
                if (bus.aes_in_ready) state_nx = AES_WAIT;
            end
            AES_WAIT: begin
                if (bus.aes_out_valid) begin
                    result_nx = bus.aes_out_data;
                    state_nx  = RES_WR;
                end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    err_nx   = 1'b1;
                    state_nx = STAT_WR;
                end else begin
                    tmo_cnt_nx = tmo_cnt + TMO_W'(1);
                end
            end
            RES_WR:   state_nx = STAT_WR;
            STAT_WR: begin
                job_cnt_nx = job_cnt + CNT_W'(1);
                err_nx     = 1'b0;
                state_nx   = IDLE;
            end
            default:  state_nx = IDLE;
        endcase

        addr_nx     = ADDR_CTRL;
        cs_nx       = 1'b0;
        we_nx       = 1'b0;
        be_nx       = '0;
        wdata_nx    = '0;
        in_valid_nx = 1'b0;
        busy_nx     = 1'b1;

        case (state_nx)
            IDLE, POLL_CHK: busy_nx = 1'b0;
            POLL_RD: begin
                busy_nx = 1'b0;
                cs_nx   = 1'b1;
                be_nx   = BE_ALL;
                addr_nx = ADDR_CTRL;
            end
            KEY_RD: begin
                cs_nx   = 1'b1;
                be_nx   = BE_ALL;
                addr_nx = ADDR_KEY;
            end
            DATA_RD: begin
                cs_nx   = 1'b1;
                be_nx   = BE_ALL;
                addr_nx = ADDR_DATA;
            end
            AES_REQ: in_valid_nx = 1'b1;
            RES_WR: begin
                cs_nx    = 1'b1;
                we_nx    = 1'b1;
                be_nx    = BE_ALL;
                addr_nx  = ADDR_RES;
                wdata_nx = result_nx;
            end
            STAT_WR: begin
                // Only the low 64 bits are enabled; the count shown is the post-increment value.
                cs_nx    = 1'b1;
                we_nx    = 1'b1;
                be_nx    = BE_STAT;
                addr_nx  = ADDR_CTRL;
                wdata_nx = {64'd0, job_cnt + CNT_W'(1), 29'd0, err_nx, 1'b1, 1'b0};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            poll_cnt   <= '0;
            tmo_cnt    <= '0;
            err        <= 1'b0;
            job_cnt    <= '0;
            key_q      <= '0;
            data_q     <= '0;
            result     <= '0;
            addr_q     <= '0;
            cs_q       <= 1'b0;
            we_q       <= 1'b0;
            be_q       <= '0;
            wdata_q    <= '0;
            in_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state      <= state_nx;
            poll_cnt   <= poll_cnt_nx;
            tmo_cnt    <= tmo_cnt_nx;
            err        <= err_nx;
            job_cnt    <= job_cnt_nx;
            key_q      <= key_nx;
            data_q     <= data_nx;
            result     <= result_nx;
            addr_q     <= addr_nx;
            cs_q       <= cs_nx;
            we_q       <= we_nx;
            be_q       <= be_nx;
            wdata_q    <= wdata_nx;
            in_valid_q <= in_valid_nx;
            busy_q     <= busy_nx;
        end
    end

    // Memory clock enable follows reset directly so it drops with reset and returns on release.
    assign bus.mem_clken      = reset_n;
    assign bus.mem_address    = addr_q;
    assign bus.mem_chipselect = cs_q;
    assign bus.mem_write      = we_q;
    assign bus.mem_byteenable = be_q;
    assign bus.mem_writedata  = wdata_q;
    assign bus.aes_key        = key_q;
    assign bus.aes_data       = data_q;
    assign bus.aes_in_valid   = in_valid_q;
    assign busy               = busy_q;

endmodule

// File: tb/tb_aes_mem_sequencer.sv
// Bench for aes_mem_sequencer: behavioural shared memory, scripted AES responder,
// and a monitor that scores memory writes and AES handshakes against queues.
module tb_aes_mem_sequencer;

    localparam int unsigned POLL = 16;
    localparam int unsigned TMO  = 1024;

    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY3 = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [127:0] PT3  = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] SENT = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
    localparam logic [127:0] JUNK = 128'hbadbadbadbadbadbadbadbadbadbad00;

    typedef struct packed {
        logic [1:0]   addr;
        logic [15:0]  be;
        logic [127:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic busy;

    aes_mem_sequencer_if bus();

    aes_mem_sequencer #(.POLL_INTERVAL(POLL), .TIMEOUT_CYCLES(TMO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    wr_t          exp_wr[$];
    logic [255:0] exp_hs[$];

    logic [127:0] mem [4];
    logic         host_we = 1'b0;
    logic [1:0]   host_addr = 2'd0;
    logic [127:0] host_wdata = '0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] stat(input logic [31:0] cnt, input logic e);
        return {64'd0, cnt, 29'd0, e, 1'b1, 1'b0};
    endfunction

    // Shared memory: byte-enabled writes, one-cycle read latency.
    always @(posedge clk) begin
        if (host_we) begin
            mem[host_addr] <= host_wdata;
        end else if (bus.mem_chipselect && bus.mem_write) begin
            for (int i = 0; i < 16; i++)
                if (bus.mem_byteenable[i]) mem[bus.mem_address][8*i +: 8] <= bus.mem_writedata[8*i +: 8];
        end
        if (bus.mem_chipselect && !bus.mem_write) bus.mem_readdata <= mem[bus.mem_address];
    end

    // Scoreboard monitor, sampling mid-cycle after the stimulus has settled.
    always begin
        @(negedge clk);
        #2;
        if (reset_n && bus.mem_chipselect && bus.mem_write) begin
            total++;
            if (exp_wr.size() == 0) begin
                bad++;
                $display("FAIL wr_unexpected: got addr=%0d be=%h data=%h, want no write",
                         bus.mem_address, bus.mem_byteenable, bus.mem_writedata);
            end else begin
                wr_t e;
                e = exp_wr.pop_front();
                chk("mem_write", 256'({bus.mem_address, bus.mem_byteenable, bus.mem_writedata}), 256'(e));
            end
        end
        if (reset_n && bus.aes_in_valid && bus.aes_in_ready) begin
            total++;
            if (exp_hs.size() == 0) begin
                bad++;
                $display("FAIL hs_unexpected: got key=%h data=%h, want no handshake", bus.aes_key, bus.aes_data);
            end else begin
                chk("aes_handshake", {bus.aes_key, bus.aes_data}, exp_hs.pop_front());
            end
        end
    end

    task automatic host_write(input logic [1:0] a, input logic [127:0] d);
        @(negedge clk);
        #1;
        host_we = 1'b1;
        host_addr = a;
        host_wdata = d;
        @(negedge clk);
        #1;
        host_we = 1'b0;
    endtask

    task automatic push_job(input logic [127:0] k, input logic [127:0] d, input logic [127:0] r,
                            input logic [31:0] cnt, input logic e);
        exp_hs.push_back({k, d});
        if (!e) exp_wr.push_back('{addr: 2'd3, be: 16'hFFFF, data: r});
        exp_wr.push_back('{addr: 2'd0, be: 16'h00FF, data: stat(cnt, e)});
    endtask

    // AES responder: hold ready low for rl cycles, then answer after ol cycles if respond.
    task automatic serve(input int rl, input int ol, input bit respond, input logic [127:0] res);
        int n;
        int stable;
        logic [127:0] k0, d0;
        n = 0;
        while (bus.aes_in_valid !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", 256'(bus.aes_in_valid), 256'(1));
        k0 = bus.aes_key;
        d0 = bus.aes_data;
        stable = 1;
        for (int i = 0; i < rl; i++) begin
            @(negedge clk);
            if (bus.aes_in_valid === 1'b1 && bus.aes_key === k0 && bus.aes_data === d0) stable++;
        end
        #1 bus.aes_in_ready = 1'b1;
        @(negedge clk);
        #1 bus.aes_in_ready = 1'b0;
        chk("req_hold_cycles", 256'(stable), 256'(rl + 1));
        chk("valid_drop", 256'(bus.aes_in_valid), 256'(0));
        if (respond) begin
            repeat (ol - 1) @(negedge clk);
            #1;
            bus.aes_out_valid = 1'b1;
            bus.aes_out_data  = res;
            @(negedge clk);
            #1;
            bus.aes_out_valid = 1'b0;
            bus.aes_out_data  = '0;
        end
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (exp_wr.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 256'(exp_wr.size()), 256'(0));
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic first_poll(input string nm);
        int n;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (bus.mem_chipselect) break;
        end
        chk(nm, 256'({n[7:0], bus.mem_write, bus.mem_address}), 256'({8'(POLL), 1'b0, 2'd0}));
    endtask

    initial begin
        int n;
        int last, reads, gap_bad, addr_bad, vseen, bseen;
        bus.aes_in_ready  = 1'b0;
        bus.aes_out_valid = 1'b0;
        bus.aes_out_data  = '0;

        host_write(2'd3, SENT);
        host_write(2'd1, KEY1);
        host_write(2'd2, PT1);
        host_write(2'd0, '0);

        @(negedge clk);
        chk("rst_ctrl", 256'({bus.mem_chipselect, bus.mem_write, bus.mem_address, bus.mem_byteenable,
                              bus.mem_clken, bus.aes_in_valid, busy}), 256'(0));
        chk("rst_wdata", 256'(bus.mem_writedata), 256'(0));
        chk("rst_key_data", {bus.aes_key, bus.aes_data}, 256'(0));
        #1 reset_n = 1'b1;
        #1 chk("clken_on", 256'(bus.mem_clken), 256'(1));

        first_poll("first_poll");

        // Idle polling with START clear.
        last = 0; reads = 1; gap_bad = 0; addr_bad = 0; vseen = 0; bseen = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (bus.aes_in_valid) vseen++;
            if (busy) bseen++;
            if (bus.mem_chipselect) begin
                reads++;
                if (bus.mem_write || bus.mem_address != 2'd0) addr_bad++;
                if (c - last != int'(POLL) + 2) gap_bad++;
                last = c;
            end
        end
        chk("idle_reads", 256'(reads), 256'(1 + 200 / (POLL + 2)));
        chk("idle_gap", 256'(gap_bad), 256'(0));
        chk("idle_addr", 256'(addr_bad), 256'(0));
        chk("idle_valid_busy", 256'({vseen[15:0], bseen[15:0]}), 256'(0));

        // Reset in the middle of AES_REQ.
        host_write(2'd0, 128'd1);
        n = 0;
        while (bus.aes_in_valid !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("rst_req_seen", 256'(bus.aes_in_valid), 256'(1));
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_ctrl", 256'({bus.mem_chipselect, bus.mem_write, bus.mem_address, bus.mem_byteenable,
                                 bus.mem_clken, bus.aes_in_valid, busy}), 256'(0));
        chk("midrst_key_data", {bus.aes_key, bus.aes_data}, 256'(0));
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b1;

        // START survives reset, so the job reruns from a cleared count.
        push_job(KEY1, PT1, CT1, 32'd1, 1'b0);
        first_poll("poll_after_rst");
        serve(0, 10, 1'b1, CT1);
        wait_done("job1_done");
        chk("job1_word3", 256'(mem[3]), 256'(CT1));
        chk("job1_word0", 256'(mem[0]), 256'(stat(32'd1, 1'b0)));

        // Stray result pulse while idle.
        @(negedge clk);
        #1;
        bus.aes_out_valid = 1'b1;
        bus.aes_out_data  = JUNK;
        @(negedge clk);
        #1;
        bus.aes_out_valid = 1'b0;
        bus.aes_out_data  = '0;
        repeat (40) @(negedge clk);
        chk("stray_words", {mem[3], mem[0]}, {CT1, stat(32'd1, 1'b0)});

        // Second job with ready held low five cycles.
        host_write(2'd1, KEY2);
        host_write(2'd2, PT2);
        push_job(KEY2, PT2, CT2, 32'd2, 1'b0);
        host_write(2'd0, 128'd1);
        serve(5, 3, 1'b1, CT2);
        wait_done("job2_done");
        chk("job2_word3", 256'(mem[3]), 256'(CT2));
        chk("job2_word0", 256'(mem[0]), 256'(stat(32'd2, 1'b0)));

        // Timeout: the AES core never answers.
        host_write(2'd1, KEY3);
        host_write(2'd2, PT3);
        push_job(KEY3, PT3, '0, 32'd3, 1'b1);
        host_write(2'd0, 128'd1);
        serve(0, 0, 1'b0, '0);
        n = 1;
        while (!(bus.mem_chipselect && bus.mem_write) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_cycles", 256'(n), 256'(TMO + 1));
        wait_done("job3_done");
        chk("job3_word0", 256'(mem[0]), 256'(stat(32'd3, 1'b1)));
        chk("job3_word3", 256'(mem[3]), 256'(CT2));

        repeat (5) @(negedge clk);
        chk("hs_queue_empty", 256'(exp_hs.size()), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/aes_mem_sequencer.md
AES_MEM_SEQUENCER -- requirements
Module: aes_mem_sequencer

Interface
REQ-001 SHALL provide parameter POLL_INTERVAL, default 16, the number of idle cycles between control-word polls.
REQ-002 SHALL provide parameter TIMEOUT_CYCLES, default 1024, the maximum number of cycles to wait for an AES result.
REQ-003 SHALL provide port clk, input, 1 bit: the single clock; all logic rises on it.
REQ-004 SHALL provide port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL provide port mem_address, output, 2 bits: word address into the 4x128 shared AES memory, port s2.
REQ-006 SHALL provide port mem_chipselect, output, 1 bit.
REQ-007 SHALL provide port mem_write, output, 1 bit.
REQ-008 SHALL provide port mem_byteenable, output, 16 bits.
REQ-009 SHALL provide port mem_writedata, output, 128 bits.
REQ-010 SHALL provide port mem_readdata, input, 128 bits: valid one cycle after a read address is presented.
REQ-011 SHALL provide port mem_clken, output, 1 bit: tied to 1 whenever reset_n is high.
REQ-012 SHALL provide ports aes_key and aes_data, outputs, 128 bits each: operands for the AES core.
REQ-013 SHALL provide ports aes_in_valid (output, 1 bit) and aes_in_ready (input, 1 bit): the request handshake.
REQ-014 SHALL provide ports aes_out_valid (input, 1 bit) and aes_out_data (input, 128 bits): the result.
REQ-015 SHALL provide port busy, output, 1 bit: high in every state except IDLE and POLL states.

Function
REQ-016 SHALL use this memory map: word0 = control/status, word1 = key, word2 = plaintext, word3 = ciphertext.
REQ-017 SHALL use this word0 layout: bit0 START (set by host), bit1 DONE, bit2 ERR, bits[63:32] job count; every other bit is written as 0.
REQ-018 SHALL implement states IDLE, POLL_RD, POLL_CHK, KEY_RD, KEY_CAP, DATA_RD, DATA_CAP, AES_REQ, AES_WAIT, RES_WR, STAT_WR.
REQ-019 IDLE SHALL count POLL_INTERVAL cycles, then go to POLL_RD.
REQ-020 A read SHALL be one cycle of chipselect=1, write=0 with the address presented, followed by a capture of mem_readdata in the next state.
REQ-021 POLL_RD SHALL read word0; POLL_CHK SHALL go to KEY_RD if bit0=1, else to IDLE.
REQ-022 KEY_RD/KEY_CAP SHALL read word1 into aes_key; DATA_RD/DATA_CAP SHALL read word2 into aes_data.
REQ-023 AES_REQ SHALL hold aes_in_valid=1 with aes_key and aes_data stable until the cycle aes_in_ready=1, then go to AES_WAIT.
REQ-024 AES_WAIT SHALL capture aes_out_data on aes_out_valid=1 and go to RES_WR.
REQ-025 AES_WAIT SHALL set an internal err flag and go to STAT_WR when TIMEOUT_CYCLES elapse without aes_out_valid.
REQ-026 aes_out_valid SHALL be ignored in every state other than AES_WAIT.
REQ-027 RES_WR SHALL issue a one-cycle write of the captured result to word3 with mem_byteenable=16'hFFFF.
REQ-028 STAT_WR SHALL issue a one-cycle write to word0 with mem_byteenable=16'h00FF: START=0, DONE=1, ERR=err, count = previous count+1, wrapping from 2^32-1 to 0; it SHALL then clear err and go to IDLE.
REQ-029 The job count SHALL be an internal register incremented on every STAT_WR, including timeouts.
REQ-030 mem_chipselect and mem_write SHALL be 0 outside the *_RD, RES_WR and STAT_WR states.
REQ-031 The block SHALL never write word1 or word2.
REQ-032 The host SHALL NOT write word0 while START=1; concurrent-write behaviour is outside this block's scope.

Reset
REQ-033 reset_n low SHALL immediately force state IDLE and clear the poll counter, timeout counter, err, job count, aes_key, aes_data, result, and all outputs (including mem_clken) to 0.
REQ-034 Reset SHALL leave memory contents untouched; after release, the first poll occurs POLL_INTERVAL cycles later.

Verification
REQ-035 Reset: assert reset_n=0 during AES_REQ -> all outputs 0 in the same cycle; after release, no write is issued until a poll sees START.
REQ-036 Nominal job: word1=000102..0F, word2=00112233..FF, word0=1; AES model answers 69C4E0D86A7B0430D8CDB78070B4C55A after 10 cycles -> word3 equals that value, and word0 reads DONE=1, START=0, ERR=0, count=1.
REQ-037 Idle: word0=0 for 200 cycles -> only reads of address 0, spaced by POLL_INTERVAL plus the read cycles; aes_in_valid stays 0.
REQ-038 Backpressure: aes_in_ready held low 5 cycles -> aes_in_valid stays 1 with aes_key and aes_data unchanged for 6 cycles, and exactly one handshake occurs.
REQ-039 Timeout: aes_out_valid never asserts -> after 1024 cycles, word0 reads DONE=1, ERR=1, count incremented; word3 is unchanged.
REQ-040 Stray result: a pulse on aes_out_valid in IDLE -> no memory write occurs; the next job completes normally with count=2.
